tof_frame_reader: RTL and testbench

Parametrised multi-sensor ToF frame acquisition engine: it replaces the single-sensor data-acquisition path of the ToF FSM. It watches N sensor interrupt lines and arbitrates pending frames round-robin. For each selected frame it issues one burst read to the shared I2C master, strips the header and footer, and streams per-zone distance words with sensor and zone tags. It sits between the I2C master and the distance consumer (UART/framebuffer).

---
 rtl/tof_frame_reader_if.sv | 25 ++
 rtl/tof_frame_reader.sv | 194 +++++++++++++++++++
 tb/tb_tof_frame_reader.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tof_frame_reader_if.sv
// I2C burst-read channel between the frame reader (master modport) and the
// shared I2C master controller (slave modport).
interface tof_frame_reader_if #(
   parameter int unsigned SID_W = 2
);
   logic             i2c_req;
   logic [SID_W-1:0] i2c_sensor_sel;
   logic [15:0]      register_address;
   logic [16:0]      nb_of_bytes;
   logic             is_read;
   logic             i2c_rvalid;
   logic [7:0]       i2c_data_in;
   logic             i2c_done;
   logic             error_in;

   modport master (
      output i2c_req, i2c_sensor_sel, register_address, nb_of_bytes, is_read,
      input  i2c_rvalid, i2c_data_in, i2c_done, error_in
   );

   modport slave (
      input  i2c_req, i2c_sensor_sel, register_address, nb_of_bytes, is_read,
      output i2c_rvalid, i2c_data_in, i2c_done, error_in
   );
endinterface

// File: rtl/tof_frame_reader.sv
// Multi-sensor ToF frame acquisition engine: synchronises sensor interrupts,
// arbitrates pending frames round-robin, issues one burst read per frame and
// streams tagged per-zone distance words with header/footer stripped.
module tof_frame_reader #(
   parameter int unsigned N_SENSORS      = 4,
   parameter int unsigned GRID           = 8,
   parameter int unsigned HEADER_BYTES   = 28,
   parameter int unsigned FOOTER_BYTES   = 24,
   parameter int unsigned BYTES_PER_ZONE = 2,
   parameter logic [15:0] DATA_REG_ADDR  = 16'h0000,
   localparam int unsigned SID_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1,
   localparam int unsigned ZONES = GRID * GRID,
   localparam int unsigned ZW    = $clog2(ZONES)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [N_SENSORS-1:0] int_mask,
   input  logic [N_SENSORS-1:0] ToF_INT,
   tof_frame_reader_if.master   i2c,
   output logic [15:0]          distance_data,
   output logic [ZW-1:0]        zone_index,
   output logic [SID_W-1:0]     sensor_index,
   output logic                 data_ready,
   output logic                 frame_done,
   output logic                 frame_error,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned ZONE_BYTES  = ZONES * BYTES_PER_ZONE;
   localparam int unsigned FRAME_BYTES = HEADER_BYTES + ZONE_BYTES + FOOTER_BYTES;
   localparam logic [16:0] HDR_C       = 17'(HEADER_BYTES);
   localparam logic [16:0] ZEND_C      = 17'(HEADER_BYTES + ZONE_BYTES);
   localparam logic [16:0] FRAME_C     = 17'(FRAME_BYTES);
   localparam logic        HDR_ODD     = 1'(HEADER_BYTES % 2);
   localparam logic [ZW-1:0] LAST_ZONE = ZW'(ZONES - 1);

   typedef enum logic [1:0] {StIdle, StSelect, StStream, StFinish} state_e;

   state_e               state_q, state_d;
   logic [N_SENSORS-1:0] sync1_q, sync2_q, sync3_q, edge_q;
   logic [N_SENSORS-1:0] pending_q, pending_d, in_flight;
   logic                 overrun_d;
   logic [SID_W-1:0]     rr_q, cur_q, sel_idx, cand;
   logic                 sel_found;
   logic [16:0]          byte_cnt_q;
   logic [ZW-1:0]        zone_cnt_q;
   logic [7:0]           hi_q;
   logic                 err_q;

   // Interrupt synchroniser plus registered rising-edge detect.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
         edge_q  <= '0;
      end else begin
         sync1_q <= ToF_INT;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         edge_q  <= sync2_q & ~sync3_q;
      end
   end

   // Round-robin pick: first pending sensor after rr_q, wrapping.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= int'(N_SENSORS); k++) begin
         cand = SID_W'((int'(rr_q) + k) % int'(N_SENSORS));
         if (!sel_found && pending_q[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   // Pending-bit update; an edge on a busy/pending sensor still re-arms it
   // so the sensor is served again after the current frame.
   always_comb begin
      in_flight = '0;
      pending_d = pending_q;
      for (int i = 0; i < int'(N_SENSORS); i++) begin
         if (state_q == StStream && cur_q == SID_W'(i)) in_flight[i] = 1'b1;
         if (state_q == StSelect && sel_found && sel_idx == SID_W'(i)) pending_d[i] = 1'b0;
      end
      pending_d = (pending_d | edge_q) & int_mask;
      overrun_d = |(edge_q & int_mask & (pending_q | in_flight));
   end

   // Arbitration state: pending flags, round-robin pointer, overrun strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q <= '0;
         rr_q      <= SID_W'(N_SENSORS - 1);
         cur_q     <= '0;
         overrun   <= 1'b0;
      end else begin
         pending_q <= pending_d;
         overrun   <= overrun_d;
         if (state_q == StSelect && sel_found) begin
            rr_q  <= sel_idx;
            cur_q <= sel_idx;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // FSM next-state logic; error and done both end the burst via FINISH.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (enable && |pending_q) state_d = StSelect;
         StSelect: state_d = sel_found ? StStream : StIdle;
         StStream: if (i2c.error_in || i2c.i2c_done) state_d = StFinish;
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // FSM outputs: burst request while streaming, frame status in FINISH.
   always_comb begin
      i2c.i2c_req          = 1'b0;
      i2c.register_address = '0;
      i2c.nb_of_bytes      = '0;
      i2c.is_read          = 1'b0;
      i2c.i2c_sensor_sel   = cur_q;
      sensor_index         = cur_q;
      frame_done           = 1'b0;
      frame_error          = 1'b0;
      busy                 = (state_q != StIdle);
      unique case (state_q)
         StStream: begin
            i2c.i2c_req          = 1'b1;
            i2c.register_address = DATA_REG_ADDR;
            i2c.nb_of_bytes      = FRAME_C;
            i2c.is_read          = 1'b1;
         end
         StFinish: begin
            if (err_q || byte_cnt_q != FRAME_C) frame_error = 1'b1;
            else                                frame_done  = 1'b1;
         end
         default: ;
      endcase
   end

   // Byte datapath: count bytes, assemble zone words, emit tagged strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_cnt_q    <= '0;
         zone_cnt_q    <= '0;
         hi_q          <= '0;
         err_q         <= 1'b0;
         data_ready    <= 1'b0;
         distance_data <= '0;
         zone_index    <= '0;
      end else begin
         data_ready <= 1'b0;
         if (state_q == StSelect) begin
            byte_cnt_q <= '0;
            zone_cnt_q <= '0;
            err_q      <= 1'b0;
         end
         if (state_q == StStream) begin
            // Holds error_in of the last streaming cycle for FINISH to report.
            err_q <= i2c.error_in;
            if (i2c.i2c_rvalid && byte_cnt_q < FRAME_C) begin
               byte_cnt_q <= byte_cnt_q + 17'd1;
               if (byte_cnt_q >= HDR_C && byte_cnt_q < ZEND_C) begin
                  // Second byte of a zone when offset from header is odd.
                  if (BYTES_PER_ZONE == 1 || (byte_cnt_q[0] ^ HDR_ODD)) begin
                     data_ready    <= 1'b1;
                     distance_data <= (BYTES_PER_ZONE == 1) ? {8'h00, i2c.i2c_data_in}
                                                            : {hi_q, i2c.i2c_data_in};
                     zone_index    <= zone_cnt_q;
                     if (zone_cnt_q != LAST_ZONE) zone_cnt_q <= zone_cnt_q + ZW'(1);
                  end else begin
                     hi_q <= i2c.i2c_data_in;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_tof_frame_reader.sv
// Self-checking bench: emulates the I2C master, keeps a scoreboard of
// expected zone words and checks arbitration, framing and error handling.
module tb_tof_frame_reader;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [3:0]  int_mask;
   logic [3:0]  ToF_INT;
   logic [15:0] distance_data;
   logic [5:0]  zone_index;
   logic [1:0]  sensor_index;
   logic        data_ready, frame_done, frame_error, overrun, busy;

   logic        enable2;
   logic [1:0]  int_mask2;
   logic [1:0]  tof2;
   logic [15:0] distance_data2;
   logic [3:0]  zone_index2;
   logic [0:0]  sensor_index2;
   logic        data_ready2, frame_done2, frame_error2, overrun2, busy2;

   int          vectors;
   int          miscompares;
   int          dr_count;
   int          ovr_count;
   logic [31:0] sb[$];

   tof_frame_reader_if #(.SID_W(2)) bus ();
   tof_frame_reader_if #(.SID_W(1)) bus2 ();

   tof_frame_reader dut (
      .clk(clk), .reset(reset), .enable(enable), .int_mask(int_mask), .ToF_INT(ToF_INT),
      .i2c(bus), .distance_data(distance_data), .zone_index(zone_index),
      .sensor_index(sensor_index), .data_ready(data_ready), .frame_done(frame_done),
      .frame_error(frame_error), .overrun(overrun), .busy(busy)
   );

   tof_frame_reader #(
      .N_SENSORS(2), .GRID(4), .HEADER_BYTES(4), .FOOTER_BYTES(0), .BYTES_PER_ZONE(1)
   ) dut2 (
      .clk(clk), .reset(reset), .enable(enable2), .int_mask(int_mask2), .ToF_INT(tof2),
      .i2c(bus2), .distance_data(distance_data2), .zone_index(zone_index2),
      .sensor_index(sensor_index2), .data_ready(data_ready2), .frame_done(frame_done2),
      .frame_error(frame_error2), .overrun(overrun2), .busy(busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] byte_val(input int sid, input int b);
      return 8'(b - 27) ^ 8'(sid << 5);
   endfunction

   // One clock; sample #1 after the edge and pop the scoreboard on strobes.
   task automatic step();
      logic [31:0] obs, exp;
      @(posedge clk);
      #1;
      if (overrun === 1'b1) ovr_count++;
      if (data_ready === 1'b1) begin
         dr_count++;
         vectors++;
         obs = {8'(sensor_index), 8'(zone_index), distance_data};
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL word_unexpected: got %h, required no strobe", obs);
         end else begin
            exp = sb.pop_front();
            if (obs !== exp) begin
               miscompares++;
               $display("FAIL word: got s/z/d %h, required %h", obs, exp);
            end
         end
      end
   endtask

   task automatic int_pulse(input logic [3:0] bits);
      ToF_INT = bits;
      repeat (3) step();
      ToF_INT = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   // Emulated I2C master. endmode: 0 done, 1 error, 2 both, 3 async reset.
   task automatic serve_frame(input int sid, input int nbytes, input int endmode,
                              input int int_at, input int exp_words, input bit exp_ok);
      int         wait_c;
      logic [7:0] hi;
      logic [7:0] b8;
      wait_c = 0;
      hi     = '0;
      while (bus.i2c_req !== 1'b1 && wait_c < 40) begin
         step();
         wait_c++;
      end
      vectors++;
      if (bus.i2c_req !== 1'b1) begin
         miscompares++;
         $display("FAIL req_timeout s%0d: i2c_req=%b, required 1", sid, bus.i2c_req);
         return;
      end
      vectors++;
      if ({bus.i2c_sensor_sel, bus.register_address, bus.nb_of_bytes, bus.is_read} !==
          {2'(sid), 16'h0000, 17'd180, 1'b1}) begin
         miscompares++;
         $display("FAIL burst_cmd: sel=%0d addr=%h nb=%0d rd=%b, required sel=%0d addr=0000 nb=180 rd=1",
                  bus.i2c_sensor_sel, bus.register_address, bus.nb_of_bytes, bus.is_read, sid);
      end
      dr_count = 0;
      for (int b = 0; b < nbytes; b++) begin
         b8 = byte_val(sid, b);
         if (b >= 28 && b < 156) begin
            if (((b - 28) % 2) == 0) hi = b8;
            else sb.push_back({8'(sid), 8'((b - 28) / 2), hi, b8});
         end
         if (int_at >= 0 && b == int_at)     ToF_INT = ToF_INT | (4'b0001 << sid);
         if (int_at >= 0 && b == int_at + 4) ToF_INT = ToF_INT & ~(4'b0001 << sid);
         bus.i2c_rvalid  = 1'b1;
         bus.i2c_data_in = b8;
         step();
      end
      bus.i2c_rvalid = 1'b0;
      if (endmode == 3) begin
         reset = 1'b1;
         #2;
         vectors++;
         if ({bus.i2c_req, bus.i2c_sensor_sel, bus.register_address, bus.nb_of_bytes,
              bus.is_read, distance_data, zone_index, sensor_index, data_ready, frame_done,
              frame_error, overrun, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_stream: req=%b busy=%b data=%h zone=%0d, required all 0",
                     bus.i2c_req, busy, distance_data, zone_index);
         end
         step();
         reset = 1'b0;
         sb.delete();
         step();
         return;
      end
      bus.i2c_done = (endmode != 1);
      bus.error_in = (endmode != 0);
      step();
      bus.i2c_done = 1'b0;
      bus.error_in = 1'b0;
      vectors++;
      if ({frame_done, frame_error, bus.i2c_req} !== {exp_ok, !exp_ok, 1'b0}) begin
         miscompares++;
         $display("FAIL frame_status s%0d: done=%b err=%b req=%b, required %b %b 0",
                  sid, frame_done, frame_error, bus.i2c_req, exp_ok, !exp_ok);
      end
      vectors++;
      if (dr_count != exp_words || sb.size() != 0) begin
         miscompares++;
         $display("FAIL word_count s%0d: got %0d (left %0d), required %0d (left 0)",
                  sid, dr_count, sb.size(), exp_words);
      end
      step();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_fall s%0d: busy=%b, required 0", sid, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      vectors++;
      if ({bus.i2c_req, bus.i2c_sensor_sel, bus.register_address, bus.nb_of_bytes,
           bus.is_read, distance_data, zone_index, sensor_index, data_ready, frame_done,
           frame_error, overrun, busy} !== '0) begin
         miscompares++;
         $display("FAIL reset_values: req=%b busy=%b nb=%0d, required all 0",
                  bus.i2c_req, busy, bus.nb_of_bytes);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_single_frame();
      int_pulse(4'b0001);
      step();
      step();
      vectors++;
      if (bus.i2c_req !== 1'b0) begin
         miscompares++;
         $display("FAIL req_early: i2c_req=%b, required 0", bus.i2c_req);
      end
      step();
      vectors++;
      if (bus.i2c_req !== 1'b1) begin
         miscompares++;
         $display("FAIL req_latency: i2c_req=%b, required 1", bus.i2c_req);
      end
      serve_frame(0, 180, 0, -1, 64, 1'b1);
      vectors++;
      if ({zone_index, distance_data} !== {6'd63, 16'h7F80}) begin
         miscompares++;
         $display("FAIL last_zone: zone=%0d data=%h, required 63 7f80", zone_index, distance_data);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      int_pulse(4'b1101);
      serve_frame(0, 180, 0, -1, 64, 1'b1);
      serve_frame(2, 180, 0, -1, 64, 1'b1);
      serve_frame(3, 180, 0, -1, 64, 1'b1);
      int_pulse(4'b1001);
      serve_frame(0, 180, 0, -1, 64, 1'b1);
      serve_frame(3, 180, 0, -1, 64, 1'b1);
   endtask

   task automatic test_errors();
      int_pulse(4'b0110);
      serve_frame(1, 50, 1, -1, 11, 1'b0);
      serve_frame(2, 180, 0, -1, 64, 1'b1);
      int_pulse(4'b1000);
      serve_frame(3, 100, 0, -1, 36, 1'b0);
      int_pulse(4'b0001);
      serve_frame(0, 180, 2, -1, 64, 1'b0);
      int_pulse(4'b0010);
      serve_frame(1, 184, 0, -1, 64, 1'b1);
   endtask

   task automatic test_overrun();
      ovr_count = 0;
      int_pulse(4'b0001);
      serve_frame(0, 180, 0, 20, 64, 1'b1);
      vectors++;
      if (ovr_count != 1) begin
         miscompares++;
         $display("FAIL overrun_count: got %0d, required 1", ovr_count);
      end
      serve_frame(0, 180, 0, -1, 64, 1'b1);
   endtask

   task automatic test_mask_enable();
      int wait_c;
      ovr_count = 0;
      int_mask  = 4'b1110;
      int_pulse(4'b0001);
      repeat (8) step();
      vectors++;
      if ({busy, bus.i2c_req, 8'(ovr_count)} !== 10'd0) begin
         miscompares++;
         $display("FAIL masked_edge: busy=%b req=%b ovr=%0d, required 0 0 0",
                  busy, bus.i2c_req, ovr_count);
      end
      int_mask = 4'b1111;
      enable   = 1'b0;
      int_pulse(4'b0100);
      step();
      step();
      int_mask = 4'b1011;
      step();
      int_mask = 4'b1111;
      enable   = 1'b1;
      repeat (8) step();
      vectors++;
      if ({busy, bus.i2c_req} !== 2'b00) begin
         miscompares++;
         $display("FAIL mask_clears_pending: busy=%b req=%b, required 0 0", busy, bus.i2c_req);
      end
      int_pulse(4'b0110);
      wait_c = 0;
      while (bus.i2c_req !== 1'b1 && wait_c < 20) begin
         step();
         wait_c++;
      end
      enable = 1'b0;
      serve_frame(1, 180, 0, -1, 64, 1'b1);
      repeat (6) step();
      vectors++;
      if ({busy, bus.i2c_req} !== 2'b00) begin
         miscompares++;
         $display("FAIL enable_low: busy=%b req=%b, required 0 0", busy, bus.i2c_req);
      end
      enable = 1'b1;
      serve_frame(2, 180, 0, -1, 64, 1'b1);
   endtask

   task automatic test_reset_mid_stream();
      int_pulse(4'b1000);
      serve_frame(3, 40, 3, -1, 0, 1'b0);
   endtask

   task automatic test_small_grid();
      int         wait_c;
      logic [7:0] b8;
      int_mask2 = 2'b11;
      enable2   = 1'b1;
      tof2      = 2'b01;
      repeat (3) step();
      tof2   = 2'b00;
      wait_c = 0;
      while (bus2.i2c_req !== 1'b1 && wait_c < 20) begin
         step();
         wait_c++;
      end
      vectors++;
      if ({bus2.i2c_req, bus2.i2c_sensor_sel, bus2.nb_of_bytes} !== {1'b1, 1'b0, 17'd20}) begin
         miscompares++;
         $display("FAIL small_cmd: req=%b sel=%0d nb=%0d, required 1 0 20",
                  bus2.i2c_req, bus2.i2c_sensor_sel, bus2.nb_of_bytes);
      end
      for (int b = 0; b < 20; b++) begin
         b8               = 8'(b * 7 + 3);
         bus2.i2c_rvalid  = 1'b1;
         bus2.i2c_data_in = b8;
         step();
         vectors++;
         if (b < 4) begin
            if (data_ready2 !== 1'b0) begin
               miscompares++;
               $display("FAIL small_header b%0d: data_ready=%b, required 0", b, data_ready2);
            end
         end else if ({data_ready2, zone_index2, distance_data2} !== {1'b1, 4'(b - 4), 8'h00, b8}) begin
            miscompares++;
            $display("FAIL small_word b%0d: dr=%b zone=%0d data=%h, required 1 %0d 00%h",
                     b, data_ready2, zone_index2, distance_data2, b - 4, b8);
         end
      end
      bus2.i2c_rvalid = 1'b0;
      bus2.i2c_done   = 1'b1;
      step();
      bus2.i2c_done = 1'b0;
      vectors++;
      if ({frame_done2, frame_error2, overrun2, bus2.i2c_req, sensor_index2, busy2} !==
          6'b100001) begin
         miscompares++;
         $display("FAIL small_done: done=%b err=%b ovr=%b req=%b sid=%0d busy=%b, required 1 0 0 0 0 1",
                  frame_done2, frame_error2, overrun2, bus2.i2c_req, sensor_index2, busy2);
      end
   endtask

   initial begin
      vectors          = 0;
      miscompares      = 0;
      dr_count         = 0;
      ovr_count        = 0;
      reset            = 1'b1;
      enable           = 1'b1;
      int_mask         = 4'b1111;
      ToF_INT          = '0;
      enable2          = 1'b0;
      int_mask2        = '0;
      tof2             = '0;
      bus.i2c_rvalid   = 1'b0;
      bus.i2c_data_in  = '0;
      bus.i2c_done     = 1'b0;
      bus.error_in     = 1'b0;
      bus2.i2c_rvalid  = 1'b0;
      bus2.i2c_data_in = '0;
      bus2.i2c_done    = 1'b0;
      bus2.error_in    = 1'b0;
      test_reset();
      test_single_frame();
      test_round_robin();
      test_errors();
      test_overrun();
      test_mask_enable();
      test_reset_mid_stream();
      test_small_grid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
